map_arbiter: RTL
================

MAP_ARBITER -- requirements
Module: map_arbiter

Interface
REQ-001 SHALL have a single clock and reset: frame_clk  in  1  sole clock, rising edge.
REQ-002 SHALL have Reset_n  in  1  reset, asynchronous and active-low.
REQ-003 SHALL have req  in  2  per-player brick-clear request (bit0 player 0, bit1 player 1), level.
REQ-004 SHALL have req_idx0 / req_idx1  in  9 each  tile index (row*20+col) of the player's request.
REQ-005 SHALL have ack  out  2  one-cycle completion pulse per player.
REQ-006 SHALL have ack_hit  out  2  valid with ack: 1 = a brick was cleared.
REQ-007 SHALL have load_valid / load_idx / load_val  in  1 / 9 / 2  direct tile write from the level loader.
REQ-008 SHALL have rd_idx0 / rd_idx1  in  9 each, and rd_val0 / rd_val1  out  2 each  combinational tile reads; out-of-range reads return 1.
REQ-009 SHALL have map_flat  out  600  tile i at bits [2i+1:2i].
REQ-010 SHALL have busy  out  1  high whenever the FSM is not in IDLE.
REQ-011 SHALL store tile codes as 0 empty, 1 wall, 2 brick; code 3 is stored as written and treated as wall.

Function
REQ-012 SHALL hold a 300 x 2-bit map register and a 3-state FSM: IDLE, CHECK, COMMIT.
REQ-013 In IDLE with load_valid=1, SHALL write load_val to load_idx on that edge, stay in IDLE, and leave pending req unserved that cycle.
REQ-014 SHALL ignore a load with load_idx>=300.
REQ-015 SHALL ignore load_valid while busy=1 (the load is lost, not queued).
REQ-016 In IDLE with load_valid=0 and req!=0, SHALL grant one player, latch that player's index, and enter CHECK.
REQ-017 Arbitration SHALL be round-robin: with one requester, grant it; with both, grant the player not granted last.
REQ-018 In CHECK, SHALL set internal hit=1 iff the latched index is <300 and its tile ==2, then enter COMMIT.
REQ-019 In COMMIT, if hit=1, SHALL write 0 to the tile.
REQ-020 In COMMIT, SHALL pulse ack[g]=1 and ack_hit[g]=hit for one cycle, update last-grant to g, and return to IDLE.
REQ-021 Latency SHALL be fixed: a request sampled in IDLE at edge N gives ack high during the cycle after edge N+2.
REQ-022 Each transaction SHALL complete once latched, even if req drops.
REQ-023 Requesters hold req until ack; a req still high the cycle after ack SHALL be treated as a new request.
REQ-024 If both players target the same brick, the first grantee SHALL get ack_hit=1 and the second ack_hit=0.
REQ-025 rd_val and map_flat SHALL reflect a COMMIT or load write from the cycle after the write edge.

Reset
REQ-026 Reset_n=0 SHALL asynchronously force state IDLE, ack=0, ack_hit=0, busy=0, and last-grant=player 1 (player 0 wins the first tie).
REQ-027 Reset SHALL load the border map: tiles in row 0, row 14, column 0 and column 19 =1; all others =0.
REQ-028 Reset mid-transaction SHALL abort it with no ack and no map write.

Configuration
REQ-029 With macro MAP_ARB_BRICK_CNT_EN defined, SHALL add brick_cnt0 / brick_cnt1  out  8 each, reset to 0, incremented in COMMIT when hit=1 for the granted player, saturating at 255.
REQ-030 Without MAP_ARB_BRICK_CNT_EN, those ports and counters SHALL not exist; all other behaviour is identical.

Verification
REQ-031 Reset then read idx 0, 21, 299 -> rd_val = 1, 0, 1; busy=0.
REQ-032 Load idx 45 val 2, then req=01 with idx0=45 -> ack=01 and ack_hit=01 exactly 3 edges after the request edge; tile 45 reads 0 next cycle.
REQ-033 req=11 with idx0=45 and idx1=46 (both bricks), held -> player 0 acked first, player 1 acked 3 cycles later; both ack_hit=1.
REQ-034 Both players target brick 60 -> first ack_hit=1, second ack_hit=0; tile 60 =0.
REQ-035 req=01 idx0=310, then idx0=20 (wall) -> ack_hit=0 for both, map unchanged; load_valid pulsed while busy=1 -> no write.
REQ-036 Assert Reset_n=0 during CHECK -> no ack, brick untouched, border map restored; with MAP_ARB_BRICK_CNT_EN, 300 hits by player 1 -> brick_cnt1=255.

Source files
------------

// File: rtl/map_arbiter_if.sv
// Request/acknowledge and level-loader signals between the players and the map arbiter.
// The arbiter takes the slave modport. The requesters and the loader take the master modport.
interface map_arbiter_if;
  logic [1:0] req;
  logic [8:0] req_idx0;
  logic [8:0] req_idx1;
  logic [1:0] ack;
  logic [1:0] ack_hit;
  logic       load_valid;
  logic [8:0] load_idx;
  logic [1:0] load_val;

  modport master (
    output req, req_idx0, req_idx1, load_valid, load_idx, load_val,
    input  ack, ack_hit
  );

  modport slave (
    input  req, req_idx0, req_idx1, load_valid, load_idx, load_val,
    output ack, ack_hit
  );
endinterface

// File: rtl/map_arbiter.sv
// Two-player brick-clear arbiter over a 20x15 tile map, with round-robin grant and fixed 3-edge latency.
// Define MAP_ARB_BRICK_CNT_EN to add saturating per-player brick counters (brick_cnt0/brick_cnt1).
//
// state  | meaning
// IDLE   | accept loader writes (priority) or grant one requester
// CHECK  | look up the latched tile and decide hit
// COMMIT | clear the brick on hit, pulse ack/ack_hit, record last grant
module map_arbiter (
  input  logic          frame_clk,
  input  logic          Reset_n,
  map_arbiter_if.slave  bus,
  input  logic [8:0]    rd_idx0,
  input  logic [8:0]    rd_idx1,
  output logic [1:0]    rd_val0,
  output logic [1:0]    rd_val1,
  output logic [599:0]  map_flat,
  output logic          busy
`ifdef MAP_ARB_BRICK_CNT_EN
  ,
  output logic [7:0]    brick_cnt0,
  output logic [7:0]    brick_cnt1
`endif
);

  localparam int         N_TILES     = 300;
  localparam int         N_COLS      = 20;
  localparam int         N_ROWS      = 15;
  localparam logic [8:0] N_TILES_IDX = 9'd300;
  localparam logic [1:0] T_EMPTY     = 2'd0;
  localparam logic [1:0] T_WALL      = 2'd1;
  localparam logic [1:0] T_BRICK     = 2'd2;

  typedef enum logic [1:0] {IDLE, CHECK, COMMIT} state_t;

  function automatic logic [1:0] border_tile(input int i);
    int row;
    int col;
    row = i / N_COLS;
    col = i % N_COLS;
    if (row == 0 || row == N_ROWS - 1 || col == 0 || col == N_COLS - 1)
      return T_WALL;
    return T_EMPTY;
  endfunction

  state_t     state_q, state_d;
  logic       grant_q, grant_d;
  logic [8:0] idx_q, idx_d;
  logic       hit_q, hit_d;
  logic       last_q, last_d;
  logic [1:0] ack_q, ack_d;
  logic [1:0] ack_hit_q, ack_hit_d;

  logic       gnt_sel;
  logic       wr_en;
  logic [8:0] wr_idx;
  logic [1:0] wr_val;
  logic [1:0] chk_tile;

  logic [1:0] map_q [N_TILES];

  // Out-of-range lookups behave like wall, so they never register a hit.
  assign chk_tile = (idx_q < N_TILES_IDX) ? map_q[idx_q] : T_WALL;
  assign rd_val0  = (rd_idx0 < N_TILES_IDX) ? map_q[rd_idx0] : T_WALL;
  assign rd_val1  = (rd_idx1 < N_TILES_IDX) ? map_q[rd_idx1] : T_WALL;

  for (genvar t = 0; t < N_TILES; t++) begin : g_flat
    assign map_flat[2*t +: 2] = map_q[t];
  end

  assign busy        = (state_q != IDLE);
  assign bus.ack     = ack_q;
  assign bus.ack_hit = ack_hit_q;

  always_comb begin
    gnt_sel = ~last_q;
    case (bus.req)
      2'b01:   gnt_sel = 1'b0;
      2'b10:   gnt_sel = 1'b1;
      default: gnt_sel = ~last_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    hit_d     = hit_q;
    last_d    = last_q;
    ack_d     = '0;
    ack_hit_d = '0;
    wr_en     = 1'b0;
    wr_idx    = idx_q;
    wr_val    = T_EMPTY;
    case (state_q)
      IDLE: begin
        if (bus.load_valid) begin
          if (bus.load_idx < N_TILES_IDX) begin
            wr_en  = 1'b1;
            wr_idx = bus.load_idx;
            wr_val = bus.load_val;
          end
        end else if (bus.req != 2'b00) begin
          grant_d = gnt_sel;
          idx_d   = gnt_sel ? bus.req_idx1 : bus.req_idx0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        hit_d   = (idx_q < N_TILES_IDX) && (chk_tile == T_BRICK);
        state_d = COMMIT;
      end
      COMMIT: begin
        if (hit_q) begin
          wr_en  = 1'b1;
          wr_idx = idx_q;
          wr_val = T_EMPTY;
        end
        ack_d[grant_q]     = 1'b1;
        ack_hit_d[grant_q] = hit_q;
        last_d             = grant_q;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      idx_q     <= '0;
      hit_q     <= 1'b0;
      last_q    <= 1'b1;
      ack_q     <= '0;
      ack_hit_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      hit_q     <= hit_d;
      last_q    <= last_d;
      ack_q     <= ack_d;
      ack_hit_q <= ack_hit_d;
    end
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < N_TILES; i++)
        map_q[i] <= border_tile(i);
    end else if (wr_en) begin
      map_q[wr_idx] <= wr_val;
    end
  end

`ifdef MAP_ARB_BRICK_CNT_EN
  logic [7:0] cnt_q [2];

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else if (state_q == COMMIT && hit_q && cnt_q[grant_q] != 8'hFF) begin
      cnt_q[grant_q] <= cnt_q[grant_q] + 8'd1;
    end
  end

  assign brick_cnt0 = cnt_q[0];
  assign brick_cnt1 = cnt_q[1];
`endif

endmodule
